// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Raster timing generator driven by a one-clock pixel strobe (pix_en).
// Horizontal/vertical position counters advance once per strobe; sync,
// data-enable, position and frame-start outputs are registered from the
// position current in that strobe cycle, so every output comes from a flop.
// Optional feature: define VGA_TIMING_LINE_REQ_EN to add the line_req /
// line_req_y prefetch request outputs. Without it those ports do not exist.
// Each porch and sync width is expected to be at least one unit long.

module vga_timing_gen #(
  parameter int H_ACTIVE      = 640,
  parameter int H_FP          = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BP          = 48,
  parameter int V_ACTIVE      = 480,
  parameter int V_FP          = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BP          = 33,
  parameter bit SYNC_POL      = 1'b0,
  parameter int LINE_REQ_LEAD = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic pix_en,
  output logic hsync,
  output logic vsync,
  output logic de,
  output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0] x,
  output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0] y,
  output logic frame_start
`ifdef VGA_TIMING_LINE_REQ_EN
  ,
  output logic line_req,
  output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0] line_req_y
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int HW1     = HW + 1;
  localparam int VW1     = VW + 1;

  // Wrap limits are held one bit wider so the increment never overflows.
  localparam logic [HW:0]   H_TOTAL_W    = HW1'(H_TOTAL);
  localparam logic [VW:0]   V_TOTAL_W    = VW1'(V_TOTAL);

  // Phase boundaries: the first count of each phase.
  localparam logic [HW-1:0] H_FP_START   = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_BP_START   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_FP_START   = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_BP_START   = VW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FP     = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BP     = 2'd3
  } phase_t;

  logic [HW-1:0] h_r;
  logic [VW-1:0] v_r;
  phase_t        h_phase_r;
  phase_t        v_phase_r;

  logic [HW:0]   h_inc_s;
  logic [HW-1:0] h_next_s;
  logic          h_wrap_s;
  logic [VW:0]   v_inc_s;
  logic [VW-1:0] v_line_next_s;
  logic          v_wrap_s;
  logic [VW-1:0] v_next_s;
  phase_t        h_phase_next_s;
  phase_t        v_phase_next_s;

  // Next position: explicit compare-and-wrap on widened increments.
  always_comb begin
    h_inc_s       = {1'b0, h_r} + {{HW{1'b0}}, 1'b1};
    h_next_s      = '0;
    h_wrap_s      = 1'b0;
    v_inc_s       = {1'b0, v_r} + {{VW{1'b0}}, 1'b1};
    v_line_next_s = '0;
    v_wrap_s      = 1'b0;
    v_next_s      = v_r;

    if (h_inc_s == H_TOTAL_W) begin
      h_next_s = '0;
      h_wrap_s = 1'b1;
    end else begin
      h_next_s = h_inc_s[HW-1:0];
      h_wrap_s = 1'b0;
    end

    if (v_inc_s == V_TOTAL_W) begin
      v_line_next_s = '0;
      v_wrap_s      = 1'b1;
    end else begin
      v_line_next_s = v_inc_s[VW-1:0];
      v_wrap_s      = 1'b0;
    end

    if (h_wrap_s) begin
      v_next_s = v_line_next_s;
    end else begin
      v_next_s = v_r;
    end
  end

  // Horizontal phase sequencing: leave a phase when the next count enters the following one.
  always_comb begin
    h_phase_next_s = h_phase_r;
    case (h_phase_r)
      PH_ACTIVE: begin
        if (h_next_s == H_FP_START) h_phase_next_s = PH_FP;
        else                        h_phase_next_s = PH_ACTIVE;
      end
      PH_FP: begin
        if (h_next_s == H_SYNC_START) h_phase_next_s = PH_SYNC;
        else                          h_phase_next_s = PH_FP;
      end
      PH_SYNC: begin
        if (h_next_s == H_BP_START) h_phase_next_s = PH_BP;
        else                        h_phase_next_s = PH_SYNC;
      end
      PH_BP: begin
        if (h_wrap_s) h_phase_next_s = PH_ACTIVE;
        else          h_phase_next_s = PH_BP;
      end
      default: h_phase_next_s = PH_ACTIVE;
    endcase
  end

  // Vertical phase sequencing: only moves on a line wrap.
  always_comb begin
    v_phase_next_s = v_phase_r;
    case (v_phase_r)
      PH_ACTIVE: begin
        if (h_wrap_s && (v_next_s == V_FP_START)) v_phase_next_s = PH_FP;
        else                                      v_phase_next_s = PH_ACTIVE;
      end
      PH_FP: begin
        if (h_wrap_s && (v_next_s == V_SYNC_START)) v_phase_next_s = PH_SYNC;
        else                                        v_phase_next_s = PH_FP;
      end
      PH_SYNC: begin
        if (h_wrap_s && (v_next_s == V_BP_START)) v_phase_next_s = PH_BP;
        else                                      v_phase_next_s = PH_SYNC;
      end
      PH_BP: begin
        if (h_wrap_s && v_wrap_s) v_phase_next_s = PH_ACTIVE;
        else                      v_phase_next_s = PH_BP;
      end
      default: v_phase_next_s = PH_ACTIVE;
    endcase
  end

  // Position counters and phase state; advance only on a pixel strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_r       <= '0;
      v_r       <= '0;
      h_phase_r <= PH_ACTIVE;
      v_phase_r <= PH_ACTIVE;
    end else if (pix_en) begin
      h_r       <= h_next_s;
      v_r       <= v_next_s;
      h_phase_r <= h_phase_next_s;
      v_phase_r <= v_phase_next_s;
    end else begin
      h_r       <= h_r;
      v_r       <= v_r;
      h_phase_r <= h_phase_r;
      v_phase_r <= v_phase_r;
    end
  end

  // Output registers: decode the position current in the strobe cycle; hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
    end else if (pix_en) begin
      hsync       <= (h_phase_r == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
      vsync       <= (v_phase_r == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
      de          <= (h_phase_r == PH_ACTIVE) && (v_phase_r == PH_ACTIVE);
      x           <= h_r;
      y           <= v_r;
      frame_start <= (h_r == '0) && (v_r == '0);
    end else begin
      hsync       <= hsync;
      vsync       <= vsync;
      de          <= de;
      x           <= x;
      y           <= y;
      frame_start <= 1'b0;
    end
  end

`ifdef VGA_TIMING_LINE_REQ_EN
  localparam logic [HW-1:0] H_REQ      = HW'(H_TOTAL - LINE_REQ_LEAD);
  localparam logic [VW:0]   V_ACTIVE_W = VW1'(V_ACTIVE);

  // Prefetch request: one pulse per upcoming visible line, carrying its line number.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_req   <= 1'b0;
      line_req_y <= '0;
    end else if (pix_en) begin
      if ((h_r == H_REQ) && ({1'b0, v_line_next_s} < V_ACTIVE_W)) begin
        line_req   <= 1'b1;
        line_req_y <= v_line_next_s;
      end else begin
        line_req   <= 1'b0;
        line_req_y <= line_req_y;
      end
    end else begin
      line_req   <= 1'b0;
      line_req_y <= line_req_y;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen using a reduced raster (32 x 21) so a full
// frame fits in a short run. A linear pixel-index model predicts every output
// each cycle; directed phases pin the model with hand-computed numbers.

module tb_vga_timing_gen;

  localparam int  HA = 16, HF = 4, HS = 6, HB = 6;
  localparam int  VA = 12, VF = 2, VS = 3, VB = 4;
  localparam int  LEAD = 3;
  localparam bit  POL = 1'b0;
  localparam int  HT = HA + HF + HS + HB;   // 32
  localparam int  VT = VA + VF + VS + VB;   // 21
  localparam int  HW = $clog2(HT);
  localparam int  VW = $clog2(VT);

  logic clk = 1'b0;
  logic rst;
  logic pix_en;
  logic hsync, vsync, de, frame_start;
  logic [HW-1:0] x;
  logic [VW-1:0] y;
`ifdef VGA_TIMING_LINE_REQ_EN
  logic          line_req;
  logic [VW-1:0] line_req_y;
`endif

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(POL), .LINE_REQ_LEAD(LEAD)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
    .frame_start(frame_start)
`ifdef VGA_TIMING_LINE_REQ_EN
    , .line_req(line_req), .line_req_y(line_req_y)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: linear pixel index ----------------
  int            p = 0;
  bit            model_valid;
  bit            pe_q;
  logic          exp_hs, exp_vs, exp_de, exp_fs;
  logic [HW-1:0] exp_x;
  logic [VW-1:0] exp_y;
`ifdef VGA_TIMING_LINE_REQ_EN
  logic          exp_lr;
  logic [VW-1:0] exp_lry;
`endif

  function automatic bit in_sync(input int pos, input int act, input int fp, input int sw);
    return (pos >= act + fp) && (pos < act + fp + sw);
  endfunction

  function automatic bit req_here(input int idx);
    return ((idx % HT) == HT - LEAD) && ((((idx / HT) + 1) % VT) < VA);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      p           <= 0;
      model_valid <= 1'b1;
      pe_q        <= 1'b0;
      exp_hs      <= ~POL;
      exp_vs      <= ~POL;
      exp_de      <= 1'b0;
      exp_x       <= '0;
      exp_y       <= '0;
      exp_fs      <= 1'b0;
`ifdef VGA_TIMING_LINE_REQ_EN
      exp_lr      <= 1'b0;
      exp_lry     <= '0;
`endif
    end else begin
      pe_q <= pix_en;
      if (pix_en) begin
        exp_x  <= HW'(p % HT);
        exp_y  <= VW'(p / HT);
        exp_de <= ((p % HT) < HA) && ((p / HT) < VA);
        exp_hs <= in_sync(p % HT, HA, HF, HS) ? POL : ~POL;
        exp_vs <= in_sync(p / HT, VA, VF, VS) ? POL : ~POL;
        exp_fs <= (p == 0);
`ifdef VGA_TIMING_LINE_REQ_EN
        exp_lr <= req_here(p);
        if (req_here(p)) exp_lry <= VW'(((p / HT) + 1) % VT);
`endif
        p <= (p + 1) % (HT * VT);
      end else begin
        exp_fs <= 1'b0;
`ifdef VGA_TIMING_LINE_REQ_EN
        exp_lr <= 1'b0;
`endif
      end
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  initial begin : compare_proc
    forever begin
      @(negedge clk);
      if (model_valid) begin
        chk("hsync", hsync, exp_hs);
        chk("vsync", vsync, exp_vs);
        chk("de", de, exp_de);
        chk("x", x, exp_x);
        chk("y", y, exp_y);
        chk("frame_start", frame_start, exp_fs);
`ifdef VGA_TIMING_LINE_REQ_EN
        chk("line_req", line_req, exp_lr);
        chk("line_req_y", line_req_y, exp_lry);
`endif
      end
    end
  end

  // ---------------- measurement monitor ----------------
  int cyc = 0, last_fs = -1, fs_period = -1, n_fs = 0;
  int n_pix = 0, n_de = 0, n_hs_low = 0, n_vs_low = 0, n_lr = 0;
  int hs_fall_x = -1, vs_fall_x = -1, vs_fall_y = -1;
  bit prev_hs = 1'b1, prev_vs = 1'b1;

  initial begin : monitor_proc
    forever begin
      @(negedge clk);
      cyc++;
      if (model_valid && frame_start === 1'b1) begin
        n_fs++;
        if (last_fs >= 0) fs_period = cyc - last_fs;
        last_fs = cyc;
      end
`ifdef VGA_TIMING_LINE_REQ_EN
      if (model_valid && line_req === 1'b1) n_lr++;
`endif
      if (model_valid && pe_q) begin
        n_pix++;
        if (de === 1'b1) n_de++;
        if (hsync === 1'b0) begin
          n_hs_low++;
          if (prev_hs) hs_fall_x = int'(x);
        end
        if (vsync === 1'b0) begin
          n_vs_low++;
          if (prev_vs) begin
            vs_fall_x = int'(x);
            vs_fall_y = int'(y);
          end
        end
        prev_hs = (hsync === 1'b1);
        prev_vs = (vsync === 1'b1);
      end
    end
  end

  // ---------------- bounded waits ----------------
  task automatic wait_xy(input int tx, input int ty, input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(posedge clk); #1;
      if (int'(x) == tx && int'(y) == ty) found = 1'b1;
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_xy: position (%0d,%0d) not reached within %0d clks", tx, ty, budget);
    end
  endtask

  task automatic wait_fs(input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk); #1;
      if (frame_start === 1'b1) found = 1'b1;
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_fs: no frame_start within %0d clks", budget);
    end
  endtask

  // ---------------- directed stimulus ----------------
  int s_de, s_hs, s_vs, s_fs, s_lr;

  initial begin : stim_proc
    rst    = 1'b1;
    pix_en = 1'b0;

    // Reset held 3 clks while pix_en toggles.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      pix_en = ~pix_en;
    end
    chk("rst_hsync", hsync, 32'd1);
    chk("rst_vsync", vsync, 32'd1);
    chk("rst_de", de, 32'd0);
    chk("rst_x", x, 32'd0);
    chk("rst_y", y, 32'd0);
    chk("rst_fs", frame_start, 32'd0);
    rst    = 1'b0;
    pix_en = 1'b0;
    @(posedge clk); #1;

    // One full line with pix_en every 2nd clk.
    s_de = n_de;
    s_hs = n_hs_low;
    pix_en = 1'b1;
    @(posedge clk); #1;
    chk("first_fs", frame_start, 32'd1);
    chk("first_de", de, 32'd1);
    chk("first_x", x, 32'd0);
    chk("first_y", y, 32'd0);
    pix_en = 1'b0;
    @(posedge clk); #1;
    chk("fs_not_stretched", frame_start, 32'd0);
    chk("hold_x_div2", x, 32'd0);
    for (int i = 1; i < HT; i++) begin
      pix_en = 1'b1;
      @(posedge clk); #1;
      pix_en = 1'b0;
      @(posedge clk); #1;
    end
    chk("line_de_count", n_de - s_de, 32'd16);
    chk("line_hs_low_count", n_hs_low - s_hs, 32'd6);
    chk("line_hs_fall_x", hs_fall_x, 32'd20);
    pix_en = 1'b1;
    @(posedge clk); #1;
    pix_en = 1'b0;
    chk("next_line_x", x, 32'd0);
    chk("next_line_y", y, 32'd1);

    // Full frame at one pixel per clk.
    pix_en = 1'b1;
    wait_fs(2000);
    s_de = n_de;
    s_vs = n_vs_low;
    s_fs = n_fs;
    s_lr = n_lr;
    wait_fs(2000);
    chk("frame_period", fs_period, 32'd672);
    chk("frame_de_count", n_de - s_de, 32'd192);
    chk("frame_vs_low_count", n_vs_low - s_vs, 32'd96);
    chk("frame_vs_fall_x", vs_fall_x, 32'd0);
    chk("frame_vs_fall_y", vs_fall_y, 32'd14);
    chk("frame_fs_count", n_fs - s_fs, 32'd1);
`ifdef VGA_TIMING_LINE_REQ_EN
    chk("frame_line_req_count", n_lr - s_lr, 32'd12);
`endif

    // Stall 50 clks at (10,5).
    wait_xy(10, 5, 1000);
    pix_en = 1'b0;
    s_fs = n_fs;
    repeat (50) begin
      @(posedge clk); #1;
    end
    chk("stall_x", x, 32'd10);
    chk("stall_y", y, 32'd5);
    chk("stall_de", de, 32'd1);
    chk("stall_fs_count", n_fs - s_fs, 32'd0);
    pix_en = 1'b1;
    @(posedge clk); #1;
    chk("resume_x", x, 32'd11);
    chk("resume_y", y, 32'd5);

    // Mid-frame reset during vsync with pix_en high in the same clk.
    wait_xy(28, 15, 1000);
    chk("pre_rst_vsync", vsync, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_hsync", hsync, 32'd1);
    chk("mid_rst_vsync", vsync, 32'd1);
    chk("mid_rst_de", de, 32'd0);
    chk("mid_rst_x", x, 32'd0);
    chk("mid_rst_y", y, 32'd0);
    chk("mid_rst_fs", frame_start, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_fs", frame_start, 32'd1);
    chk("post_rst_x", x, 32'd0);
    chk("post_rst_y", y, 32'd0);

    // Irregular strobe pattern (every 3rd clk) across several lines.
    for (int i = 0; i < 300; i++) begin
      pix_en = (i % 3 == 0);
      @(posedge clk); #1;
    end
    pix_en = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Sequences the VGA raster from the single-cycle pixel-enable pulse produced by the pixel clock divider. It advances horizontal and vertical position counters once per enable, and decodes sync, data-enable and frame markers for the framebuffer read path and the VGA pins. An optional line-prefetch request tells the pixel fetch engine to start loading the next active line ahead of time.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)
- LINE_REQ_LEAD, 8, pixels before line end at which line_req fires; legal range 1..H_FP+H_SYNC+H_BP

Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL (525); HW = $clog2(H_TOTAL); VW = $clog2(V_TOTAL).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- pix_en  in  1  one-clk pixel strobe from the divider
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- de  out  1  data enable; high for visible pixels
- x  out  HW  horizontal position of the current pixel
- y  out  VW  vertical position of the current pixel
- frame_start  out  1  one-clk pulse when position (0,0) is presented
- line_req  out  1  one-clk prefetch request (only with the macro defined)
- line_req_y  out  VW  line number requested (only with the macro defined)

## Operation
- Internal counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1). They change only in cycles where pix_en=1.
- In a pix_en cycle:
  - All outputs are registered from the current (h,v).
  - h then increments. At H_TOTAL-1, h wraps to 0 and v increments.
  - v wraps to 0 after V_TOTAL-1.
- Horizontal phase FSM, decoded from h:
  - ACTIVE: h < H_ACTIVE
  - FP
  - SYNC: H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC
  - BP
  - The phase order is fixed: ACTIVE→FP→SYNC→BP→ACTIVE.
- Vertical phase FSM: same four phases on v, using the V_* parameters.
- Output decode:
  - hsync = SYNC_POL while the horizontal phase is SYNC; otherwise ~SYNC_POL.
  - vsync follows the same rule on the vertical phase.
  - de = 1 iff h < H_ACTIVE and v < V_ACTIVE.
  - x = h and y = v as raw counts; they are not gated by de.
- frame_start: set to 1 for exactly one clk in the pix_en cycle that registers (0,0). It is 0 in every other clk.
- Gaps in pix_en: outputs and counters hold. frame_start and line_req are never stretched.
- Reset (any cycle, including mid-frame, with priority over pix_en), effective the next clk:
  - h=0, v=0, x=0, y=0, de=0
  - hsync = vsync = ~SYNC_POL
  - frame_start=0, line_req=0, line_req_y=0
- Arithmetic:
  - Counters are unsigned, HW/VW bits wide, with an explicit compare-and-wrap. They never rely on natural overflow.
  - The next-line number (v+1, wrapping V_TOTAL-1→0) is computed at VW+1 bits before the compare.

## Timing
- Latency: 1 clk from the pix_en cycle to the outputs showing that position. Outputs then hold until the next pix_en.
- With a divider DIV=2, outputs update every 2 clks.
- With pix_en held at 1, there is one pixel per clk.
- First pix_en after reset registers (0,0): frame_start=1, de=1, x=0, y=0.
- The hsync edge to asserted occurs on the registration of h=H_ACTIVE+H_FP (656). The deassert edge occurs on h=752.
- The vsync asserted window covers the registrations of v=490 and v=491, for all h.
- Glitch-free: all outputs come straight from flops.

## Configuration
- Macro VGA_TIMING_LINE_REQ_EN.
- Defined: line_req and line_req_y exist.
  - line_req pulses for one clk in the pix_en cycle registering h = H_TOTAL-LINE_REQ_LEAD, but only when the next line (v+1 with wrap) is < V_ACTIVE.
  - line_req_y = that next-line number, registered in the same cycle as line_req and held until the next line_req.
- Undefined: the ports and their logic are absent. All other behaviour is unchanged.

## Test plan
- Reset values: assert rst for 3 clks with pix_en toggling → hsync=1, vsync=1, de=0, x=0, y=0, frame_start=0.
- Full line, pix_en every 2nd clk:
  - de high for 640 consecutive pixel positions.
  - hsync low for exactly 96 positions, starting at x=656.
  - The next line begins at x=0, y=1.
- Full frame, pix_en constant 1:
  - frame_start period is exactly 420000 clks.
  - vsync low for exactly 1600 clks, starting at y=490, x=0.
  - de count per frame = 307200.
- Stall: hold pix_en=0 for 50 clks at x=300, y=100 → all outputs frozen, no extra frame_start. Resume continues at x=301.
- Mid-frame reset at x=700, y=495 with pix_en=1 in the same clk → next clk shows reset values. The first subsequent pix_en gives frame_start=1, x=0, y=0.
- With VGA_TIMING_LINE_REQ_EN defined:
  - line_req fires at x=792, y=524 with line_req_y=0.
  - line_req fires at x=792, y=0 with line_req_y=1.
  - No line_req on y=479..523.
  - Exactly 480 pulses per frame.
